// File: rtl/btn_pkg.sv
// btn_pkg: FSM state encoding and default 50 MHz timing constants for btn_event
package btn_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, LONG} state_t;
  localparam int DEF_LONG_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_PERIOD = 10_000_000;
endpackage

// File: rtl/btn_event_if.sv
// btn_event_if: button level in (btn_state), registered event pulses and held level out
interface btn_event_if;
  logic btn_state, press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;
  modport master (
    output btn_state,
    input  press_pulse, release_pulse, short_press, long_press, repeat_pulse, held
  );
  modport slave (
    input  btn_state,
    output press_pulse, release_pulse, short_press, long_press, repeat_pulse, held
  );
endinterface

// File: rtl/btn_event.sv
// btn_event: turns a clean button level into press/release/short/long/repeat events
// Ports: clk, rst_n (sync, active low); b (slave): btn_state in, registered pulses and held out
module btn_event import btn_pkg::*; #(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN     = 1
) (
  input logic        clk,
  input logic        rst_n,
  btn_event_if.slave b
);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_PERIOD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_PERIOD - 1);
  state_t        state_q;
  logic          btn_q;
  logic [HW-1:0] hold_q;
  logic [RW-1:0] rep_q;
  logic          rise, fall;
  assign rise = b.btn_state & ~btn_q;
  assign fall = ~b.btn_state & btn_q;
  // btn_q resets high so a button held through reset must be seen released before it counts as a press.
  // A release in IDLE is not part of any sequence, so it emits nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      btn_q           <= 1'b1;
      hold_q          <= '0;
      rep_q           <= '0;
      b.press_pulse   <= 1'b0;
      b.release_pulse <= 1'b0;
      b.short_press   <= 1'b0;
      b.long_press    <= 1'b0;
      b.repeat_pulse  <= 1'b0;
      b.held          <= 1'b0;
    end else begin
      btn_q           <= b.btn_state;
      b.press_pulse   <= 1'b0;
      b.release_pulse <= 1'b0;
      b.short_press   <= 1'b0;
      b.long_press    <= 1'b0;
      b.repeat_pulse  <= 1'b0;
      case (state_q)
        IDLE: if (rise) begin
          state_q       <= HOLD;
          hold_q        <= '0;
          b.press_pulse <= 1'b1;
          b.held        <= 1'b1;
        end
        HOLD: if (fall) begin
          state_q         <= IDLE;
          b.release_pulse <= 1'b1;
          b.short_press   <= 1'b1;
          b.held          <= 1'b0;
        end else if (hold_q == HOLD_LAST) begin
          state_q      <= LONG;
          rep_q        <= '0;
          b.long_press <= 1'b1;
        end else begin
          hold_q <= hold_q + 1'b1;
        end
        LONG: if (fall) begin
          state_q         <= IDLE;
          b.release_pulse <= 1'b1;
          b.held          <= 1'b0;
        end else if (REPEAT_EN != 0) begin
          if (rep_q == REP_LAST) begin
            rep_q          <= '0;
            b.repeat_pulse <= 1'b1;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: random and directed button stimulus checked per cycle against an elapsed-time model
module tb_btn_event;
  localparam int L = 10;
  localparam int P = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  always #5 clk = ~clk;
  btn_event_if ia();
  btn_event_if ib();
  assign ia.btn_state = btn;
  assign ib.btn_state = btn;
  btn_event #(.LONG_CYCLES(L), .REPEAT_PERIOD(P), .REPEAT_EN(1)) dut_a (.clk(clk), .rst_n(rst_n), .b(ia.slave));
  btn_event #(.LONG_CYCLES(L), .REPEAT_PERIOD(P), .REPEAT_EN(0)) dut_b (.clk(clk), .rst_n(rst_n), .b(ib.slave));
  logic [5:0] oa, ob;
  assign oa = {ia.press_pulse, ia.release_pulse, ia.short_press, ia.long_press, ia.repeat_pulse, ia.held};
  assign ob = {ib.press_pulse, ib.release_pulse, ib.short_press, ib.long_press, ib.repeat_pulse, ib.held};
  typedef struct { logic prev; bit active; int t0; } mdl_t;
  typedef struct { int cyc; logic [5:0] a; logic [5:0] b; } exp_t;
  mdl_t m[2];
  exp_t q[$];
  exp_t x;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  // Events are derived from the time elapsed since the press: long at exactly L, repeats every P after that.
  function automatic logic [5:0] model(int k, logic r, logic bt, bit ren);
    logic [5:0] e;
    int d;
    e = '0;
    if (!r) begin
      m[k].prev = 1'b1;
      m[k].active = 1'b0;
      return e;
    end
    if (!m[k].active && bt && !m[k].prev) begin
      m[k].active = 1'b1;
      m[k].t0 = cyc;
      e[5] = 1'b1;
      e[0] = 1'b1;
    end else if (m[k].active) begin
      d = cyc - m[k].t0;
      if (!bt) begin
        e[4] = 1'b1;
        e[3] = (d <= L);
        m[k].active = 1'b0;
      end else begin
        e[0] = 1'b1;
        e[2] = (d == L);
        e[1] = ren && d > L && ((d - L) % P) == 0;
      end
    end
    m[k].prev = bt;
    return e;
  endfunction
  task automatic step(input logic r, input logic bt);
    @(negedge clk);
    #1;
    rst_n = r;
    btn = bt;
    cyc++;
    q.push_back('{cyc, model(0, r, bt, 1'b1), model(1, r, bt, 1'b0)});
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      x = q.pop_front();
      checks++;
      if (oa !== x.a) begin
        failures++;
        $display("FAIL dut_a cyc=%0d got=%b exp=%b (press,release,short,long,repeat,held)", x.cyc, oa, x.a);
      end
      checks++;
      if (ob !== x.b) begin
        failures++;
        $display("FAIL dut_b cyc=%0d got=%b exp=%b (press,release,short,long,repeat,held)", x.cyc, ob, x.b);
      end
    end
  end
  initial begin
    int n;
    logic v;
    repeat (3) step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    repeat (25) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    repeat (11) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (14) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (12) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (16) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    repeat (6) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (30) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    for (int i = 0; i < 150; i++) begin
      n = int'($urandom_range(1, 30));
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) step(1'b0, v);
      repeat (n) step(1'b1, v);
    end
    repeat (3) step(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0 pending", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_event.md
BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000, hold time in clk cycles from press_pulse to long_press; legal range >= 2.
REQ-002 Parameter REPEAT_PERIOD, default 10_000_000, clk cycles between successive repeat_pulse outputs; legal range >= 1.
REQ-003 Parameter REPEAT_EN, default 1, enables (1) or disables (0) repeat_pulse generation.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 btn_state  input  1  clean button level, 1 = pressed; already debounced, synchronous to clk.
REQ-007 press_pulse  output  1  one-cycle pulse on press.
REQ-008 release_pulse  output  1  one-cycle pulse on release.
REQ-009 short_press  output  1  one-cycle pulse, release before long threshold.
REQ-010 long_press  output  1  one-cycle pulse at long threshold while held.
REQ-011 repeat_pulse  output  1  one-cycle pulse per REPEAT_PERIOD after long_press while held.
REQ-012 held  output  1  level, 1 from press_pulse cycle through last pressed cycle.

Function
REQ-013 All outputs SHALL be registered; every pulse SHALL be exactly one clk cycle wide.
REQ-014 Previous sample btn_q SHALL be held; rising sample (btn_state=1, btn_q=0) at edge k SHALL assert press_pulse and held from edge k, latency one cycle from input change.
REQ-015 FSM states SHALL be IDLE, HOLD, LONG; IDLE->HOLD on rising sample, HOLD->LONG at threshold, HOLD/LONG->IDLE on falling sample.
REQ-016 Hold counter SHALL clear on press, increment each HOLD cycle, width $clog2(LONG_CYCLES+1), never wrap.
REQ-017 long_press SHALL assert exactly LONG_CYCLES cycles after press_pulse if btn_state stays 1 throughout; FSM enters LONG on the same edge.
REQ-018 In LONG with REPEAT_EN=1, repeat_pulse SHALL assert REPEAT_PERIOD cycles after long_press and every REPEAT_PERIOD cycles thereafter until release; repeat counter clears on entering LONG and after each repeat_pulse.
REQ-019 With REPEAT_EN=0, repeat_pulse SHALL remain 0 and LONG SHALL persist until release.
REQ-020 Falling sample (btn_state=0, btn_q=1) SHALL assert release_pulse and deassert held on the same edge; in HOLD it SHALL also assert short_press in that cycle.
REQ-021 Release in LONG SHALL produce release_pulse only; no short_press, no further repeat_pulse.
REQ-022 Release sampled on the edge where long threshold would be reached: release SHALL win; short_press and release_pulse asserted, long_press not asserted.
REQ-023 Release sampled on the edge a repeat_pulse is due: release SHALL win; no repeat_pulse.
REQ-024 A press re-sampled one cycle after release SHALL start a fresh sequence with counters cleared.

Reset
REQ-025 While rst_n=0 at a clk edge: state IDLE, counters 0, all outputs 0.
REQ-026 btn_q SHALL reset to 1, so a button held through reset release produces no press_pulse until btn_state is first sampled 0 and then 1.
REQ-027 Reset asserted mid-HOLD or mid-LONG SHALL abort the sequence with no release_pulse or short_press emitted.

Structure
REQ-028 Package btn_pkg SHALL hold the FSM state enum (IDLE, HOLD, LONG) and default timing constants (LONG_CYCLES, REPEAT_PERIOD at 50 MHz).
REQ-029 Implementation SHALL be one module, no sub-module; edge detect, FSM and two counters inline.

Verification (LONG_CYCLES=10, REPEAT_PERIOD=4, REPEAT_EN=1)
REQ-030 Press at edge 0, release at edge 5 -> press_pulse cycle 0; release_pulse and short_press cycle 5; no long_press; held cycles 0-4.
REQ-031 Press at edge 0, hold 25 cycles -> long_press cycle 10; repeat_pulse cycles 14, 18, 22; release_pulse cycle 25 without short_press.
REQ-032 Press at edge 0, release sampled at edge 10 -> short_press and release_pulse cycle 10; long_press never asserted.
REQ-033 btn_state=1 during and after reset deassertion for 20 cycles, then 0, then 1 at edge 30 -> no pulses before cycle 30; press_pulse cycle 30.
REQ-034 Reset asserted at cycle 12 while held -> all outputs 0 next cycle; no release_pulse; subsequent clean press works normally.
REQ-035 REPEAT_EN=0, hold 30 cycles -> long_press cycle 10 only; repeat_pulse never asserted.
